add_share_ctrl: RTL and testbench

//   Shares one combinational 16-bit add3 adder among NREQ requesters.
//   - Round-robin arbitration selects one request at a time.
//   - The winner's operands are registered onto the adder inputs.
//   - The block waits SETTLE cycles for the gate-level adder to settle.
//   - The sum is captured and returned on a valid/ready response channel.

---
 rtl/add_share_ctrl.sv | 130 +++++++++++++
 tb/tb_add_share_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_share_ctrl.sv
// Round-robin front end for one shared combinational adder: grants one requester,
// launches its operands, waits SETTLE cycles, then returns the captured sum.
module add_share_ctrl #(
    parameter int NREQ   = 4,
    parameter int WIDTH  = 16,
    parameter int SETTLE = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*WIDTH-1:0]      req_a,
    input  logic [NREQ*WIDTH-1:0]      req_b,
    output logic [WIDTH-1:0]           add_a,
    output logic [WIDTH-1:0]           add_b,
    input  logic [WIDTH-1:0]           add_o,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [WIDTH-1:0]           rsp_data,
    output logic [$clog2(NREQ)-1:0]    rsp_id,
    output logic                       busy
);

    localparam int ID_W  = $clog2(NREQ);
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  add_a_q, add_a_d;
    logic [WIDTH-1:0]  add_b_q, add_b_d;
    logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   grant;
    logic              found;

    function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] p, input int k);
        rr_idx = ID_W'((int'(p) + k) % NREQ);
    endfunction

    // Scan downward so the requester closest to ptr is the last (winning) assignment.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[rr_idx(ptr_q, k)]) begin
                grant = rr_idx(ptr_q, k);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        rsp_valid_d = rsp_valid_q;
        req_ready   = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    req_ready[grant] = 1'b1;
                    for (int i = 0; i < NREQ; i++) begin
                        if (grant == ID_W'(i)) begin
                            add_a_d = req_a[i*WIDTH +: WIDTH];
                            add_b_d = req_b[i*WIDTH +: WIDTH];
                        end
                    end
                    rsp_id_d = grant;
                    ptr_d    = (grant == ID_W'(NREQ - 1)) ? '0 : grant + 1'b1;
                    cnt_d    = CNT_W'(SETTLE - 1);
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    rsp_data_d  = add_o;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_valid = rsp_valid_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_add_share_ctrl.sv
// Directed and randomized bench for add_share_ctrl with a behavioural adder on add_a/add_b.
module tb_add_share_ctrl;

    localparam int NREQ   = 4;
    localparam int WIDTH  = 16;
    localparam int SETTLE = 3;
    localparam int ID_W   = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a = '0;
    logic [NREQ*WIDTH-1:0] req_b = '0;
    logic [WIDTH-1:0]      add_a, add_b, add_o;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b0;
    logic [WIDTH-1:0]      rsp_data;
    logic [ID_W-1:0]       rsp_id;
    logic                  busy;

    int checks = 0;
    int passed = 0;

    add_share_ctrl #(.NREQ(NREQ), .WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .add_a(add_a), .add_b(add_b), .add_o(add_o),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
    );

    assign add_o = add_a + add_b;

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, checks);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
        req_valid[i] = 1'b1;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (rsp_valid !== 1'b1) n = -1;
    endtask

    task automatic do_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         output logic [WIDTH-1:0] data, output int id, output int lat);
        int n;
        rsp_ready = 1'b0;
        set_req(i, a, b);
        #1;
        n = 0;
        while (req_ready[i] !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        tick();
        req_valid[i] = 1'b0;
        wait_rsp(lat);
        data = rsp_data;
        id   = int'(rsp_id);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
        checks++; if (add_a !== 16'h0) $display("FAIL reset_add_a got=%h exp=0000", add_a); else passed++;
        checks++; if (add_b !== 16'h0) $display("FAIL reset_add_b got=%h exp=0000", add_b); else passed++;
        checks++; if (rsp_data !== 16'h0) $display("FAIL reset_rsp_data got=%h exp=0000", rsp_data); else passed++;
        checks++; if (rsp_id !== 2'd0) $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); else passed++;
        checks++; if (req_ready !== 4'b0000) $display("FAIL reset_req_ready got=%b exp=0000", req_ready); else passed++;
        rst = 1'b0;
        set_req(0, 16'h0005, 16'h0006);
        tick();
        req_valid = '0;
        checks++; if (busy !== 1'b1) $display("FAIL pre_rst_busy got=%b exp=1", busy); else passed++;
        checks++; if (add_a !== 16'h0005) $display("FAIL pre_rst_add_a got=%h exp=0005", add_a); else passed++;
        tick();
        #2 rst = 1'b1;
        #1;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL midwait_rsp_valid got=%b exp=0", rsp_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL midwait_busy got=%b exp=0", busy); else passed++;
        checks++; if (add_a !== 16'h0) $display("FAIL midwait_add_a got=%h exp=0000", add_a); else passed++;
        checks++; if (add_b !== 16'h0) $display("FAIL midwait_add_b got=%h exp=0000", add_b); else passed++;
        #2 rst = 1'b0;
        repeat (5) tick();
        checks++; if (rsp_valid !== 1'b0) $display("FAIL discarded_op_rsp got=%b exp=0", rsp_valid); else passed++;
        req_valid = 4'b0011;
        #1;
        checks++; if (req_ready !== 4'b0001) $display("FAIL post_rst_grant got=%b exp=0001", req_ready); else passed++;
        req_valid = '0;
        #1;
    endtask

    task automatic test_single_op();
        int n;
        rsp_ready = 1'b0;
        set_req(0, 16'h1234, 16'h0FF0);
        #1;
        checks++; if (req_ready !== 4'b0001) $display("FAIL single_req_ready got=%b exp=0001", req_ready); else passed++;
        tick();
        req_valid = '0;
        wait_rsp(n);
        checks++; if (n !== SETTLE) $display("FAIL single_latency got=%0d exp=%0d", n, SETTLE); else passed++;
        checks++; if (rsp_data !== 16'h2224) $display("FAIL single_rsp_data got=%h exp=2224", rsp_data); else passed++;
        checks++; if (rsp_id !== 2'd0) $display("FAIL single_rsp_id got=%0d exp=0", rsp_id); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL single_busy got=%b exp=1", busy); else passed++;
        checks++; if (add_b !== 16'h0FF0) $display("FAIL single_add_b got=%h exp=0ff0", add_b); else passed++;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL single_rsp_drop got=%b exp=0", rsp_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL single_idle got=%b exp=0", busy); else passed++;
        checks++; if (add_a !== 16'h1234) $display("FAIL single_add_a_hold got=%h exp=1234", add_a); else passed++;
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] d;
        int id, lat;
        do_op(0, 16'hFFFF, 16'h0001, d, id, lat);
        checks++; if (d !== 16'h0000) $display("FAIL wrap1_data got=%h exp=0000", d); else passed++;
        checks++; if (id !== 0) $display("FAIL wrap1_id got=%0d exp=0", id); else passed++;
        checks++; if (lat !== SETTLE) $display("FAIL wrap1_latency got=%0d exp=%0d", lat, SETTLE); else passed++;
        do_op(3, 16'h8000, 16'h8000, d, id, lat);
        checks++; if (d !== 16'h0000) $display("FAIL wrap2_data got=%h exp=0000", d); else passed++;
        checks++; if (id !== 3) $display("FAIL wrap2_id got=%0d exp=3", id); else passed++;
        checks++; if (add_a !== 16'h8000) $display("FAIL wrap2_add_a_hold got=%h exp=8000", add_a); else passed++;
    endtask

    task automatic test_round_robin();
        int n;
        int exp_g;
        rsp_ready = 1'b0;
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, WIDTH'(i * 16'h0100), WIDTH'(i));
        rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            exp_g = k % NREQ;
            checks++; if (req_ready !== 4'(1 << exp_g)) $display("FAIL rr_grant%0d got=%b exp=%b", k, req_ready, 4'(1 << exp_g)); else passed++;
            tick();
            wait_rsp(n);
            checks++; if (rsp_id !== ID_W'(exp_g)) $display("FAIL rr_id%0d got=%0d exp=%0d", k, rsp_id, exp_g); else passed++;
            checks++; if (rsp_data !== WIDTH'(exp_g * 16'h0101)) $display("FAIL rr_data%0d got=%h exp=%h", k, rsp_data, WIDTH'(exp_g * 16'h0101)); else passed++;
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        #1;
    endtask

    task automatic test_backpressure();
        int n;
        rsp_ready = 1'b0;
        set_req(1, 16'h00AA, 16'h0011);
        set_req(2, 16'h0001, 16'h0002);
        #1;
        checks++; if (req_ready !== 4'b0010) $display("FAIL bp_grant got=%b exp=0010", req_ready); else passed++;
        tick();
        req_valid[1] = 1'b0;
        wait_rsp(n);
        checks++; if (n !== SETTLE) $display("FAIL bp_latency got=%0d exp=%0d", n, SETTLE); else passed++;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++; if (rsp_valid !== 1'b1) $display("FAIL bp_valid_c%0d got=%b exp=1", c, rsp_valid); else passed++;
            checks++; if (rsp_data !== 16'h00BB) $display("FAIL bp_data_c%0d got=%h exp=00bb", c, rsp_data); else passed++;
            checks++; if (rsp_id !== 2'd1) $display("FAIL bp_id_c%0d got=%0d exp=1", c, rsp_id); else passed++;
            checks++; if (req_ready !== 4'b0000) $display("FAIL bp_req_ready_c%0d got=%b exp=0000", c, req_ready); else passed++;
            checks++; if (busy !== 1'b1) $display("FAIL bp_busy_c%0d got=%b exp=1", c, busy); else passed++;
        end
        rsp_ready = 1'b1;
        tick();
        checks++; if (rsp_valid !== 1'b0) $display("FAIL bp_release_valid got=%b exp=0", rsp_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL bp_release_busy got=%b exp=0", busy); else passed++;
        checks++; if (req_ready !== 4'b0100) $display("FAIL bp_next_grant got=%b exp=0100", req_ready); else passed++;
        req_valid = '0;
        rsp_ready = 1'b0;
        #1;
    endtask

    task automatic test_random();
        int accepts, resps, g, exp_id;
        int skip [NREQ];
        logic [WIDTH-1:0] exp_d;
        accepts = 0;
        resps   = 0;
        exp_id  = 0;
        exp_d   = '0;
        for (int i = 0; i < NREQ; i++) skip[i] = 0;
        req_valid = '0;
        for (int cyc = 0; cyc < 3030; cyc++) begin
            if (cyc < 3000) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                        set_req(i, WIDTH'($urandom), WIDTH'($urandom));
                    end
                end
                rsp_ready = ($urandom_range(0, 2) != 0);
            end else begin
                req_valid = '0;
                rsp_ready = 1'b1;
            end
            #1;
            g = -1;
            for (int i = 0; i < NREQ; i++) if (req_valid[i] && req_ready[i]) g = i;
            if (g >= 0) begin
                accepts++;
                exp_d  = req_a[g*WIDTH +: WIDTH] + req_b[g*WIDTH +: WIDTH];
                exp_id = g;
                for (int i = 0; i < NREQ; i++) begin
                    if (i != g && req_valid[i]) begin
                        skip[i]++;
                        checks++; if (skip[i] >= NREQ) $display("FAIL rnd_starve req=%0d skipped=%0d limit=%0d", i, skip[i], NREQ - 1); else passed++;
                    end
                end
                skip[g] = 0;
            end
            if (rsp_valid && rsp_ready) begin
                resps++;
                checks++; if (rsp_data !== exp_d) $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc, rsp_data, exp_d); else passed++;
                checks++; if (rsp_id !== ID_W'(exp_id)) $display("FAIL rnd_id cyc=%0d got=%0d exp=%0d", cyc, rsp_id, exp_id); else passed++;
            end
            tick();
            if (g >= 0) req_valid[g] = 1'b0;
        end
        checks++; if (resps !== accepts) $display("FAIL rnd_count responses=%0d accepts=%0d", resps, accepts); else passed++;
        rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_wrap();
        test_round_robin();
        test_backpressure();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
